// File: rtl/fir_serial_mac_if.sv
// Handshake, delay-line and coefficient-port bundle for fir_serial_mac.
// The master side is the surrounding filter and delay line; the slave side is the sequencer/MAC.
interface fir_serial_mac_if #(
  parameter int Win      = 16,
  parameter int Wc       = 16,
  parameter int Wout     = 16,
  parameter int Num_coef = 17
);
  localparam int SW = (Num_coef > 1) ? $clog2(Num_coef) : 1;

  logic                   din_valid;
  logic                   din_ready;
  logic                   ce_out;
  logic [SW-1:0]          sel_out;
  logic signed [Win-1:0]  tap_in;
  logic                   coef_we;
  logic [SW-1:0]          coef_addr;
  logic signed [Wc-1:0]   coef_din;
  logic signed [Wout-1:0] dout;
  logic                   dout_valid;

  modport master (
    output din_valid, tap_in, coef_we, coef_addr, coef_din,
    input  din_ready, ce_out, sel_out, dout, dout_valid
  );

  modport slave (
    input  din_valid, tap_in, coef_we, coef_addr, coef_din,
    output din_ready, ce_out, sel_out, dout, dout_valid
  );
endinterface

// File: rtl/fir_serial_mac.sv
// Serial FIR sequencer: accepts a sample, walks the shared tap delay line,
// multiply-accumulates against a local coefficient bank and emits a rounded, saturated result.
//
// state | meaning
// IDLE  | ready for a sample; coefficient writes honoured here only
// MAC   | N+1 cycles; selects taps 0..N-1 and accumulates the previous cycle's tap
// DONE  | round, saturate and register the result
module fir_serial_mac #(
  parameter int Win      = 16,
  parameter int Wc       = 16,
  parameter int Wout     = 16,
  parameter int Num_coef = 17,
  parameter int Shift    = 15
) (
  input logic            clk,
  input logic            rst,
  fir_serial_mac_if.slave bus
);

  localparam int SW = (Num_coef > 1) ? $clog2(Num_coef) : 1;
  localparam int CW = $clog2(Num_coef + 1);
  localparam int PW = Win + Wc;
  localparam int AW = PW + $clog2(Num_coef);
  localparam int RW = AW + 1;

  localparam logic signed [RW-1:0] HALF =
    (Shift > 0) ? (RW'(1) << ((Shift > 0) ? Shift - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] MAXV = {{(RW-Wout+1){1'b0}}, {(Wout-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-Wout+1){1'b1}}, {(Wout-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [Wout-1:0] dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic signed [Wc-1:0]   coef_q [Num_coef];

  logic                   din_ready;
  logic [SW-1:0]          sel;
  logic                   accept;
  logic                   coef_wr;
  logic [SW-1:0]          tap_idx;
  logic signed [Wc-1:0]   coef_cur;
  logic signed [PW-1:0]   prod;
  logic signed [RW-1:0]   rnd;

  assign accept  = bus.din_valid & din_ready;
  assign coef_wr = (state_q == IDLE) && bus.coef_we &&
                   ({1'b0, bus.coef_addr} < (SW+1)'(Num_coef));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (cnt_q == CW'(Num_coef)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; sel holds the last tap during the final accumulate cycle
  always_comb begin
    din_ready = 1'b0;
    sel       = '0;
    case (state_q)
      IDLE: din_ready = 1'b1;
      MAC:  sel = (cnt_q < CW'(Num_coef)) ? SW'(cnt_q) : SW'(Num_coef - 1);
      default: ;
    endcase
  end

  // tap_in lags sel by one cycle, so cycle m pairs with coefficient m-1
  assign tap_idx  = (cnt_q == '0) ? '0 : SW'(cnt_q - CW'(1));
  assign coef_cur = coef_q[tap_idx];
  assign prod     = bus.tap_in * coef_cur;
  assign rnd      = (RW'(acc_q) + HALF) >>> Shift;

  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          acc_d = '0;
        end
      end
      MAC: begin
        if (cnt_q != '0) acc_d = acc_q + AW'(prod);
        if (cnt_q != CW'(Num_coef)) cnt_d = cnt_q + CW'(1);
      end
      DONE: begin
        dout_valid_d = 1'b1;
        if (rnd > MAXV)      dout_d = {1'b0, {(Wout-1){1'b1}}};
        else if (rnd < MINV) dout_d = {1'b1, {(Wout-1){1'b0}}};
        else                 dout_d = rnd[Wout-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < Num_coef; i++) coef_q[i] <= '0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      if (coef_wr) coef_q[bus.coef_addr] <= bus.coef_din;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.ce_out     = accept;
  assign bus.sel_out    = sel;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: models the delay line around the DUT and checks each
// result against a direct convolution of the sample history with the coefficients.
module tb_fir_serial_mac;
  localparam int N     = 17;
  localparam int SHIFT = 15;
  localparam int SW    = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_serial_mac_if #(.Win(16), .Wc(16), .Wout(16), .Num_coef(N)) bus ();

  fir_serial_mac #(.Win(16), .Wc(16), .Wout(16), .Num_coef(N), .Shift(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Delay line: shifts on ce_out, registers the selector (not affected by rst)
  logic signed [15:0] din_s = '0;
  logic signed [15:0] dl [N] = '{default: '0};
  logic [SW-1:0]      sel_r = '0;

  always @(posedge clk) begin
    if (bus.ce_out) begin
      for (int i = N - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= din_s;
    end
    sel_r <= bus.sel_out;
  end
  assign bus.tap_in = dl[sel_r];

  // Reference model state
  int mc   [N];
  int hist [N];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint model_out();
    longint acc = 0;
    for (int k = 0; k < N; k++) acc += longint'(hist[k]) * longint'(mc[k]);
    if (SHIFT > 0) acc += longint'(1) <<< (SHIFT - 1);
    acc = acc >>> SHIFT;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic hist_push(input int x);
    for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endtask

  // Single-cycle coefficient write issued from a negedge; in_idle is the bench's view of the DUT state
  task automatic write_coef(input int a, input int v, input bit in_idle);
    bus.coef_we   = 1'b1;
    bus.coef_addr = SW'(a);
    bus.coef_din  = 16'(v);
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (in_idle && a < N) mc[a] = v;
  endtask

  // wmode: 0 none, 1 write together with acceptance, 2 write during MAC
  task automatic send_sample(input int x, input int wmode, input int wa, input int wv,
                             output longint got);
    int waitc, dv_at, dv_cnt, rdy_low, ce_cnt, sel_match, exp_sel;
    longint exp_v;
    waitc = 0;
    while (!bus.din_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 50) check_val("ready_wait", waitc, 0);
    bus.din_valid = 1'b1;
    din_s = 16'(x);
    if (wmode == 1) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = SW'(wa);
      bus.coef_din  = 16'(wv);
      if (wa < N) mc[wa] = wv;
    end
    hist_push(x);
    exp_v = model_out();
    #1;
    ce_cnt = bus.ce_out ? 1 : 0;
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.coef_we   = 1'b0;
    dv_at = -1; dv_cnt = 0; rdy_low = 0; sel_match = 0; got = 0;
    for (int k = 1; k <= 40; k++) begin
      if (wmode == 2 && k == 5) begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = SW'(wa);
        bus.coef_din  = 16'(wv);
      end
      if (wmode == 2 && k == 6) bus.coef_we = 1'b0;
      #1;
      if (bus.ce_out) ce_cnt++;
      if (!bus.din_ready && dv_at < 0) rdy_low++;
      exp_sel = (k - 1 < N - 1) ? k - 1 : N - 1;
      if (k <= N + 1 && int'(bus.sel_out) == exp_sel) sel_match++;
      if (bus.dout_valid) begin
        dv_cnt++;
        if (dv_at < 0) begin
          dv_at = k;
          got   = bus.dout;
        end
      end
      if (dv_at >= 0 && k == dv_at + 1) break;
      @(negedge clk);
    end
    bus.coef_we = 1'b0;
    check_val("dout", got, exp_v);
    check_val("valid_latency", dv_at, N + 3);
    check_val("valid_width", dv_cnt, 1);
    check_val("ready_low_cycles", rdy_low, N + 2);
    check_val("ce_pulses", ce_cnt, 1);
    check_val("sel_sequence", sel_match, N + 1);
  endtask

  longint got;
  int     acc_at [$];
  int     dvs, w;

  initial begin
    for (int i = 0; i < N; i++) begin mc[i] = 0; hist[i] = 0; end
    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_din  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_ready", bus.din_ready, 1);
    check_val("rst_sel", bus.sel_out, 0);
    check_val("rst_dout", bus.dout, 0);
    check_val("rst_valid", bus.dout_valid, 0);
    check_val("rst_ce", bus.ce_out, 0);

    // Impulse response
    for (int k = 0; k < N; k++) write_coef(k, (k + 1) * 1024, 1'b1);
    for (int k = 0; k < N; k++) send_sample(0, 0, 0, 0, got);
    for (int i = 0; i <= N; i++) begin
      send_sample((i == 0) ? 32 : 0, 0, 0, 0, got);
      check_val("impulse", got, (i < N) ? i + 1 : 0);
    end

    // Back-to-back acceptances with din_valid held
    @(negedge clk);
    bus.din_valid = 1'b1;
    din_s = '0;
    for (int j = 0; j < 60; j++) begin
      #1;
      if (bus.ce_out) begin
        acc_at.push_back(j);
        hist_push(0);
      end
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    check_val("held_accepts", acc_at.size(), 3);
    if (acc_at.size() >= 3) begin
      check_val("held_period1", acc_at[1] - acc_at[0], N + 3);
      check_val("held_period2", acc_at[2] - acc_at[1], N + 3);
    end
    repeat (25) @(negedge clk);

    // Saturation
    for (int k = 0; k < N; k++) write_coef(k, 32767, 1'b1);
    for (int k = 0; k < N; k++) send_sample(32767, 0, 0, 0, got);
    check_val("sat_pos", got, 32767);
    for (int k = 0; k < N; k++) send_sample(-32768, 0, 0, 0, got);
    check_val("sat_neg", got, -32768);

    // Rounding
    write_coef(0, 1, 1'b1);
    for (int k = 1; k < N; k++) write_coef(k, 0, 1'b1);
    send_sample(16384, 0, 0, 0, got);  check_val("round_16384", got, 1);
    send_sample(16383, 0, 0, 0, got);  check_val("round_16383", got, 0);
    send_sample(-16384, 0, 0, 0, got); check_val("round_m16384", got, 0);
    send_sample(-16385, 0, 0, 0, got); check_val("round_m16385", got, -1);

    // Write gating
    for (int k = 0; k < N; k++) send_sample(20000, 0, 0, 0, got);
    send_sample(20000, 2, N - 1, 32767, got);
    check_val("mac_write_ignored", got, 1);
    send_sample(20000, 0, 0, 0, got);
    write_coef(20, 32767, 1'b1);
    send_sample(20000, 0, 0, 0, got);
    check_val("addr20_ignored", got, 1);
    send_sample(20000, 1, 0, 32767, got);
    check_val("same_cycle_write", got, 19999);

    // Reset in the middle of MAC
    bus.din_valid = 1'b1;
    din_s = 16'(1000);
    hist_push(1000);
    @(negedge clk);
    bus.din_valid = 1'b0;
    dvs = 0; w = 0;
    while (bus.sel_out != SW'(8) && w < 40) begin
      if (bus.dout_valid) dvs++;
      @(negedge clk);
      w++;
    end
    check_val("rst_mid_sel8", bus.sel_out, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) mc[i] = 0;
    #1;
    check_val("rst_mid_sel", bus.sel_out, 0);
    check_val("rst_mid_ready", bus.din_ready, 1);
    for (int j = 0; j < 25; j++) begin
      if (bus.dout_valid) dvs++;
      @(negedge clk);
    end
    check_val("rst_mid_no_valid", dvs, 0);
    send_sample(12345, 0, 0, 0, got);
    check_val("rst_mid_zero_coef", got, 0);

    // Randomized samples, coefficients and write timing
    for (int k = 0; k < N; k++) write_coef(k, int'($urandom_range(0, 65535)) - 32768, 1'b1);
    for (int t = 0; t < 30; t++) begin
      int x, wm, wa, wv;
      x  = int'($urandom_range(0, 65535)) - 32768;
      wm = int'($urandom_range(0, 2));
      wa = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, N - 1));
      wv = int'($urandom_range(0, 65535)) - 32768;
      send_sample(x, wm, wa, wv, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
